// File: rtl/jedro_1_imem_ctrl.sv
// Instruction-memory slave for the jedro_1 IFU: answers req/gnt/rvalid fetches from a
// word-addressed RAM with configurable wait states, and accepts program images on a load port.
module jedro_1_imem_ctrl #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                    MEM_WORDS   = 1024,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    input  logic [DATA_WIDTH-1:0] instr_addr_i,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  load_we_i,
    input  logic [DATA_WIDTH-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_wdata_i
);

    localparam int                    AW        = $clog2(MEM_WORDS);
    localparam logic [DATA_WIDTH-1:0] MEM_BYTES = DATA_WIDTH'(4 * MEM_WORDS);
    localparam logic [DATA_WIDTH-1:0] NOP       = DATA_WIDTH'(32'h0000_0013);

    localparam logic [0:0] READY = 1'b0;
    localparam logic [0:0] WAIT  = 1'b1;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [0:0]            state;
    logic [3:0]            wait_cnt;
    logic                  pending;
    logic [DATA_WIDTH-1:0] pend_data;
    logic                  pend_err;

    logic [DATA_WIDTH-1:0] fetch_off;
    logic                  fetch_err;
    logic [AW-1:0]         fetch_idx;
    logic [DATA_WIDTH-1:0] fetch_word;
    logic                  accept;

    logic [DATA_WIDTH-1:0] load_off;
    logic                  load_ok;
    logic [AW-1:0]         load_idx;

    // Offsets wrap mod 2^DATA_WIDTH, so addresses below BASE_ADDR are caught by the explicit compare.
    assign fetch_off  = instr_addr_i - BASE_ADDR;
    assign fetch_err  = (instr_addr_i[1:0] != 2'b00) || (instr_addr_i < BASE_ADDR) ||
                        (fetch_off >= MEM_BYTES);
    assign fetch_idx  = AW'(fetch_off >> 2);
    assign fetch_word = fetch_err ? NOP : mem[fetch_idx];

    assign load_off = load_addr_i - BASE_ADDR;
    assign load_ok  = (load_addr_i[1:0] == 2'b00) && (load_addr_i >= BASE_ADDR) &&
                      (load_off < MEM_BYTES);
    assign load_idx = AW'(load_off >> 2);

    assign accept      = instr_req_i && (state == READY);
    assign instr_gnt_o = accept;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= READY;
            wait_cnt       <= 4'd0;
            pending        <= 1'b0;
            pend_data      <= NOP;
            pend_err       <= 1'b0;
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= NOP;
            instr_err_o    <= 1'b0;
        end else begin
            instr_rvalid_o <= 1'b0;
            case (state)
                READY: begin
                    if (accept) begin
                        if (WAIT_STATES == 0) begin
                            instr_rvalid_o <= 1'b1;
                            instr_rdata_o  <= fetch_word;
                            instr_err_o    <= fetch_err;
                        end else begin
                            pending   <= 1'b1;
                            pend_data <= fetch_word;
                            pend_err  <= fetch_err;
                            wait_cnt  <= 4'(WAIT_STATES);
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Leaving at count 1 makes the response land in the cycle the counter reads 0.
                    if (wait_cnt <= 4'd1) begin
                        wait_cnt       <= 4'd0;
                        state          <= READY;
                        pending        <= 1'b0;
                        instr_rvalid_o <= pending;
                        instr_rdata_o  <= pend_data;
                        instr_err_o    <= pend_err;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    // Fetch capture reads mem before this write lands, giving read-before-write.
    always_ff @(posedge clk_i) begin
        if (load_we_i && load_ok) begin
            mem[load_idx] <= load_wdata_i;
        end
    end

endmodule
